// File: rtl/maxpool2x2_stream_param.sv
// maxpool2x2_stream_param: streaming 2x2/stride-2 max-pool with valid/ready, frame markers and sof error.
// Define MAXPOOL_SIGNED_EN for two's-complement channel compares (unsigned otherwise).
module maxpool2x2_stream_param #(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24,
  parameter int CH    = 3,
  parameter int DW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sof,
  input  logic [CH*DW-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic [CH*DW-1:0] out_data,
  output logic           sof_err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = IMG_W > 2 ? $clog2(IMG_W / 2) : 1;
  logic [CW-1:0] col, ec;
  logic [RW-1:0] row, er;
  logic [AW-1:0] idx;
  logic [CH*DW-1:0] h_left, h, res, lb_rd;
  logic [CH*DW-1:0] lb [IMG_W/2];
  logic acc, bad_sof, col_end, row_end;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign bad_sof = acc && in_sof && (col != '0 || row != '0);
  // a misplaced sof restarts the frame: the beat is treated as pixel (0,0)
  assign ec = bad_sof ? '0 : col;
  assign er = bad_sof ? '0 : row;
  assign col_end = ec == CW'(IMG_W - 1);
  assign row_end = er == RW'(IMG_H - 1);
  assign idx = AW'(ec >> 1);
  assign lb_rd = lb[idx];
  genvar g;
  for (g = 0; g < CH; g = g + 1) begin : g_ch
    logic [DW-1:0] a, b, l, hm, rm;
    assign a = h_left[g*DW +: DW];
    assign b = in_data[g*DW +: DW];
    assign l = lb_rd[g*DW +: DW];
`ifdef MAXPOOL_SIGNED_EN
    assign hm = $signed(a) > $signed(b) ? a : b;
    assign rm = $signed(l) > $signed(hm) ? l : hm;
`else
    assign hm = a > b ? a : b;
    assign rm = l > hm ? l : hm;
`endif
    assign h[g*DW +: DW] = hm;
    assign res[g*DW +: DW] = rm;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      h_left <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      sof_err <= 1'b0;
    end else begin
      sof_err <= bad_sof;
      if (acc) begin
        col <= col_end ? '0 : ec + 1'b1;
        row <= col_end ? (row_end ? '0 : er + 1'b1) : er;
        if (!ec[0]) h_left <= in_data;
      end
      if (acc && ec[0] && er[0]) begin
        out_valid <= 1'b1;
        out_data <= res;
        out_last <= col_end && row_end;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
  // row 0 always rewrites every entry before row 1 reads it, so no reset needed
  always_ff @(posedge clk)
    if (acc && ec[0] && !er[0]) lb[idx] <= h;
endmodule

// File: tb/tb_maxpool2x2_stream_param.sv
// tb_maxpool2x2_stream_param: directed + random checks of the 2x2 max-pool against a frame-array model.
module tb_maxpool2x2_stream_param;
  logic clk = 1'b0, rst = 1'b1;
  logic s_in_valid, s_in_ready, s_in_sof, s_out_valid, s_out_ready, s_out_last, s_sof_err;
  logic [7:0] s_in_data, s_out_data;
  logic b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready, b_out_last, b_sof_err;
  logic [23:0] b_in_data, b_out_data;
  int n_asrt = 0, n_fail = 0, n_sof = 0, m_pos = 0;
  bit rnd_or = 0;
  logic [7:0] s_got_d[$], m_exp[$], m_fr[16];
  logic s_got_l[$], m_last[$], b_got_l[$];
  logic [23:0] b_got_d[$];

  maxpool2x2_stream_param #(.IMG_W(4), .IMG_H(4), .CH(1), .DW(8)) u_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sof(s_in_sof),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_last(s_out_last),
    .out_data(s_out_data), .sof_err(s_sof_err));
  maxpool2x2_stream_param u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .out_data(b_out_data), .sof_err(b_sof_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) begin s_got_d.push_back(s_out_data); s_got_l.push_back(s_out_last); end
    if (b_out_valid && b_out_ready) begin b_got_d.push_back(b_out_data); b_got_l.push_back(b_out_last); end
    if (s_sof_err) n_sof++;
  end

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
`ifdef MAXPOOL_SIGNED_EN
    return $signed(a) > $signed(b) ? a : b;
`else
    return a > b ? a : b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_or) s_out_ready = 1'($urandom_range(0, 1));
  endtask

  // model: frame held as a flat pixel array; window max emitted at each bottom-right pixel
  task automatic model_push(input logic [7:0] d, input logic sof);
    if (sof) m_pos = 0;
    m_fr[m_pos] = d;
    if ((m_pos / 4) % 2 == 1 && m_pos % 2 == 1) begin
      m_exp.push_back(mx(mx(m_fr[m_pos], m_fr[m_pos-1]), mx(m_fr[m_pos-4], m_fr[m_pos-5])));
      m_last.push_back(m_pos == 15);
    end
    m_pos = (m_pos + 1) % 16;
  endtask

  task automatic s_send(input logic [7:0] d, input logic sof);
    bit ok = 0;
    s_in_valid = 1'b1; s_in_data = d; s_in_sof = sof;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = s_in_ready;
      tick();
    end
    s_in_valid = 1'b0; s_in_sof = 1'b0;
    chk("send_accept", 32'(ok), 1);
    if (ok) model_push(d, sof);
  endtask

  task automatic check_s(input string tag, input int n, input logic [39:0] ed, input logic [4:0] el);
    repeat (3) tick();
    chk({tag, "_count"}, s_got_d.size(), n);
    for (int i = 0; i < n; i++)
      if (i < s_got_d.size()) begin
        chk({tag, "_data"}, s_got_d[i], ed[i*8 +: 8]);
        chk({tag, "_last"}, 32'(s_got_l[i]), 32'(el[i]));
      end
    s_got_d.delete(); s_got_l.delete();
  endtask

  initial begin
    logic [7:0] v;
    logic [23:0] e;
    s_in_valid = 0; s_in_sof = 0; s_in_data = 0; s_out_ready = 1;
    b_in_valid = 0; b_in_sof = 0; b_in_data = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(s_out_valid), 0);
    chk("rst_last", 32'(s_out_last), 0);
    chk("rst_data", s_out_data, 0);
    chk("rst_sof_err", 32'(s_sof_err), 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_in_ready", 32'(s_in_ready), 1);
    tick();
    // test 1: 0..15 gives 5,7,13,15 one cycle after acceptance
    for (int p = 0; p < 16; p++) begin
      s_send(8'(p), p == 0);
      chk("t1_valid", 32'(s_out_valid), 32'(p == 5 || p == 7 || p == 13 || p == 15));
      if (p == 5 || p == 7 || p == 13 || p == 15) begin
        chk("t1_data", s_out_data, p);
        chk("t1_last", 32'(s_out_last), 32'(p == 15));
      end
    end
    chk("t1_sof_err", n_sof, 0);
    check_s("t1", 4, {8'd0, 8'd15, 8'd13, 8'd7, 8'd5}, 5'b01000);
    // test 2: stall on the first output
    for (int p = 0; p < 6; p++) s_send(8'(p), p == 0);
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 8'd6;
    repeat (3) begin
      @(negedge clk);
      chk("t2_in_ready", 32'(s_in_ready), 0);
      chk("t2_hold_valid", 32'(s_out_valid), 1);
      chk("t2_hold_data", s_out_data, 5);
      chk("t2_hold_last", 32'(s_out_last), 0);
    end
    @(posedge clk); #1;
    s_out_ready = 1; s_in_valid = 0;
    for (int p = 6; p < 16; p++) s_send(8'(p), 1'b0);
    check_s("t2", 4, {8'd0, 8'd15, 8'd13, 8'd7, 8'd5}, 5'b01000);
    // test 4: misplaced sof at pixel index 6
    for (int p = 0; p < 6; p++) s_send(8'(p), p == 0);
    for (int p = 0; p < 16; p++) begin
      s_send(8'(100 + p), p == 0);
      if (p < 2) chk("t4_sof_err", 32'(s_sof_err), 32'(p == 0));
    end
    check_s("t4", 5, {8'd115, 8'd113, 8'd107, 8'd105, 8'd5}, 5'b10000);
    chk("t4_sof_pulses", n_sof, 1);
    // test 5: reset mid-frame
    for (int p = 0; p < 10; p++) s_send(8'(p), p == 0);
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("t5_valid", 32'(s_out_valid), 0);
    chk("t5_sof_err", 32'(s_sof_err), 0);
    chk("t5_in_ready", 32'(s_in_ready), 1);
    tick();
    s_got_d.delete(); s_got_l.delete();
    for (int p = 0; p < 16; p++) s_send(8'(p), p == 0);
    check_s("t5", 4, {8'd0, 8'd15, 8'd13, 8'd7, 8'd5}, 5'b01000);
    // test 6: signedness window
    for (int p = 0; p < 16; p++)
      s_send(p == 0 ? 8'h80 : p == 1 ? 8'h7F : p == 4 ? 8'hFF : p == 5 ? 8'h01 : 8'h00, p == 0);
`ifdef MAXPOOL_SIGNED_EN
    check_s("t6", 4, {8'd0, 8'd0, 8'd0, 8'd0, 8'h7F}, 5'b01000);
`else
    check_s("t6", 4, {8'd0, 8'd0, 8'd0, 8'd0, 8'hFF}, 5'b01000);
`endif
    // test 7: random data, gaps and backpressure vs model
    m_pos = 0; m_exp.delete(); m_last.delete();
    rnd_or = 1;
    for (int p = 0; p < 3; p++) s_send(8'($urandom), 1'b0);
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 16; p++) begin
        repeat ($urandom_range(0, 2)) tick();
        s_send(8'($urandom), p == 0 && f != 1);
      end
    rnd_or = 0; s_out_ready = 1;
    repeat (5) tick();
    chk("t7_count", s_got_d.size(), m_exp.size());
    foreach (m_exp[i])
      if (i < s_got_d.size()) begin
        chk("t7_data", s_got_d[i], m_exp[i]);
        chk("t7_last", 32'(s_got_l[i]), 32'(m_last[i]));
      end
    chk("t7_sof_pulses", n_sof, 2);
    // test 3: default 24x24x3, two back-to-back frames
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 24; r++)
        for (int k = 0; k < 24; k++) begin
          b_in_valid = 1; b_in_sof = r == 0 && k == 0;
          for (int c = 0; c < 3; c++) b_in_data[c*8 +: 8] = 8'((r * 24 + k + c) % 256);
          @(negedge clk);
          chk("t3_in_ready", 32'(b_in_ready), 1);
          @(posedge clk); #1;
        end
    b_in_valid = 0; b_in_sof = 0;
    repeat (4) tick();
    chk("t3_count", b_got_d.size(), 288);
    for (int i = 0; i < 288 && i < b_got_d.size(); i++) begin
      int wr, wc;
      wr = (i % 144) / 12; wc = i % 12;
      for (int c = 0; c < 3; c++) begin
        v = 8'((2 * wr * 24 + 2 * wc + c) % 256);
        for (int d = 1; d < 4; d++) v = mx(v, 8'(((2 * wr + d / 2) * 24 + 2 * wc + d % 2 + c) % 256));
        e[c*8 +: 8] = v;
      end
      chk("t3_data", b_got_d[i], 32'(e));
      chk("t3_last", 32'(b_got_l[i]), 32'(i % 144 == 143));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
